// File: rtl/wash_phase_sequencer.sv
// Purpose: times fill/soak/wash/rinse/spin phases for one programme and drives valve/motor enables.
// Latency: accepted start shows the first phase one edge later; phase changes are registered, enables are decoded combinationally.
// Backpressure: none; lid=1 freezes the phase timer, cancel aborts to IDLE. Optional EXTRA_RINSE_EN adds RINSE2 for mode 1.
module wash_phase_sequencer #(
  parameter int TICK_DIV    = 1000,
  parameter int CNT_W       = 8,
  parameter int FILL_TICKS  = 10,
  parameter int SOAK_TICKS  = 30,
  parameter int WASH_TICKS  = 40,
  parameter int RINSE_TICKS = 20,
  parameter int SPIN_TICKS  = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             lid,
  input  logic             cancel,
  output logic             busy,
  output logic [2:0]       phase,
  output logic             water_valve,
  output logic             soak_en,
  output logic             wash_en,
  output logic             rinse_en,
  output logic             spin_en,
  output logic             paused,
  output logic [CNT_W-1:0] remaining,
  output logic             done,
  output logic             aborted
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

`ifdef EXTRA_RINSE_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, FILL = 3'd1, SOAK = 3'd2, WASH = 3'd3, RINSE = 3'd4, SPIN = 3'd5, RINSE2 = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, FILL = 3'd1, SOAK = 3'd2, WASH = 3'd3, RINSE = 3'd4, SPIN = 3'd5
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             tick;
  logic             phase_end;
  state_t           first_st;
  state_t           next_st;

  // Tick budget loaded on entry to each phase.
  function automatic logic [CNT_W-1:0] ticks_of(input state_t s);
    case (s)
      FILL:    ticks_of = CNT_W'(FILL_TICKS);
      SOAK:    ticks_of = CNT_W'(SOAK_TICKS);
      WASH:    ticks_of = CNT_W'(WASH_TICKS);
      RINSE:   ticks_of = CNT_W'(RINSE_TICKS);
`ifdef EXTRA_RINSE_EN
      RINSE2:  ticks_of = CNT_W'(RINSE_TICKS);
`endif
      SPIN:    ticks_of = CNT_W'(SPIN_TICKS);
      default: ticks_of = '0;
    endcase
  endfunction

  // Programme sequencing: the phase that follows s for latched mode m.
  function automatic state_t next_of(input state_t s, input logic [1:0] m);
    case (s)
      FILL:    next_of = (m == 2'd2) ? WASH : SOAK;
      SOAK:    next_of = WASH;
      WASH:    next_of = RINSE;
`ifdef EXTRA_RINSE_EN
      RINSE:   next_of = (m == 2'd1) ? RINSE2 : SPIN;
      RINSE2:  next_of = SPIN;
`else
      RINSE:   next_of = SPIN;
`endif
      default: next_of = IDLE;
    endcase
  endfunction

  assign tick      = (presc_q == PRESC_MAX);
  // A zero-length phase ends on its first unpaused cycle; otherwise the 1->0 tick ends it.
  assign phase_end = !lid && ((rem_q == '0) || (tick && (rem_q == CNT_W'(1))));
  assign first_st  = (mode == 2'd3) ? SPIN : FILL;
  assign next_st   = next_of(state_q, mode_q);

  // Next-state logic: start acceptance, cancel, lid freeze, tick countdown and phase advance.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    presc_d   = presc_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    if (state_q == IDLE) begin
      if (start && !lid && !cancel && (mode != 2'd0)) begin
        mode_d  = mode;
        state_d = first_st;
        rem_d   = ticks_of(first_st);
        presc_d = '0;
      end
    end else if (cancel) begin
      state_d   = IDLE;
      rem_d     = '0;
      presc_d   = '0;
      aborted_d = 1'b1;
    end else if (lid) begin
      state_d = state_q;
    end else if (phase_end) begin
      state_d = next_st;
      rem_d   = ticks_of(next_st);
      presc_d = '0;
      done_d  = (next_st == IDLE);
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        rem_d = rem_q - CNT_W'(1);
      end
    end
  end

  // State, timer and pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= 2'd0;
      presc_q   <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Output decode: enables drop immediately when the lid opens.
  always_comb begin
    busy        = (state_q != IDLE);
    phase       = state_q;
    paused      = busy && lid;
    water_valve = (state_q == FILL) && !paused;
    soak_en     = (state_q == SOAK) && !paused;
    wash_en     = (state_q == WASH) && !paused;
`ifdef EXTRA_RINSE_EN
    rinse_en    = ((state_q == RINSE) || (state_q == RINSE2)) && !paused;
`else
    rinse_en    = (state_q == RINSE) && !paused;
`endif
    spin_en     = (state_q == SPIN) && !paused;
    remaining   = rem_q;
    done        = done_q;
    aborted     = aborted_q;
  end

endmodule

// File: tb/tb_wash_phase_sequencer.sv
// Purpose: self-checking bench for wash_phase_sequencer with a phase-list model plus literal expectations.
// Latency: model predicts the DUT outputs for every cycle; literals pin cycle numbers from the test plan.
// Backpressure: lid pauses and cancel aborts are driven as directed vectors.
module tb_wash_phase_sequencer;
  localparam int TD = 2;
  localparam int FT = 2;
  localparam int ST = 3;
  localparam int WT = 3;
  localparam int RT = 2;
  localparam int PT = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       lid = 1'b0;
  logic       cancel = 1'b0;
  logic       busy, water_valve, soak_en, wash_en, rinse_en, spin_en, paused, done, aborted;
  logic [2:0] phase;
  logic [7:0] remaining;

  int checks = 0;
  int failures = 0;

  wash_phase_sequencer #(
    .TICK_DIV(TD), .CNT_W(8), .FILL_TICKS(FT), .SOAK_TICKS(ST),
    .WASH_TICKS(WT), .RINSE_TICKS(RT), .SPIN_TICKS(PT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .lid(lid), .cancel(cancel),
    .busy(busy), .phase(phase), .water_valve(water_valve), .soak_en(soak_en),
    .wash_en(wash_en), .rinse_en(rinse_en), .spin_en(spin_en), .paused(paused),
    .remaining(remaining), .done(done), .aborted(aborted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the programme is a list of phase codes; each phase lasts a fixed number of
  // unpaused cycles and remaining is the tick budget minus whole ticks elapsed.
  bit m_busy = 0;
  bit m_done = 0;
  bit m_abort = 0;
  int m_code = 0;
  int m_ticks = 0;
  int m_elapsed = 0;
  int m_seq[$];

  function automatic int tick_tab(input int c);
    case (c)
      1: return FT;
      2: return ST;
      3: return WT;
      4: return RT;
      5: return PT;
      default: return 0;
    endcase
  endfunction

  function automatic int len_of(input int t);
    return (t == 0) ? 1 : t * TD;
  endfunction

  task automatic m_enter();
    m_code    = m_seq.pop_front();
    m_ticks   = tick_tab(m_code);
    m_elapsed = 0;
  endtask

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_busy = 0; m_done = 0; m_abort = 0; m_code = 0; m_ticks = 0; m_elapsed = 0;
        m_seq.delete();
      end else begin
        m_done = 0;
        m_abort = 0;
        if (!m_busy) begin
          if (start && !lid && !cancel && mode != 2'd0) begin
            case (mode)
              2'd1:    m_seq = '{1, 2, 3, 4, 5};
              2'd2:    m_seq = '{1, 3, 4, 5};
              default: m_seq = '{5};
            endcase
            m_busy = 1;
            m_enter();
          end
        end else if (cancel) begin
          m_busy = 0;
          m_abort = 1;
          m_seq.delete();
        end else if (!lid) begin
          m_elapsed++;
          if (m_elapsed == len_of(m_ticks)) begin
            if (m_seq.size() == 0) begin
              m_busy = 0;
              m_done = 1;
            end else begin
              m_enter();
            end
          end
        end
      end
    end
  end

  logic [19:0] exp_v, act_v;
  logic [2:0]  exp_ph;
  logic [7:0]  exp_rem;
  logic        exp_pz;

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      exp_ph  = m_busy ? 3'(m_code) : 3'd0;
      exp_rem = m_busy ? 8'(m_ticks - m_elapsed / TD) : 8'd0;
      exp_pz  = m_busy && lid;
      exp_v = {m_busy, exp_ph,
               exp_ph == 3'd1 && !exp_pz, exp_ph == 3'd2 && !exp_pz, exp_ph == 3'd3 && !exp_pz,
               exp_ph == 3'd4 && !exp_pz, exp_ph == 3'd5 && !exp_pz,
               exp_pz, m_done, m_abort, exp_rem};
      act_v = {busy, phase, water_valve, soak_en, wash_en, rinse_en, spin_en,
               paused, done, aborted, remaining};
      chk("model", 32'(act_v), 32'(exp_v));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Pulse start for one cycle; returns in cycle 1 of the programme.
  task automatic go(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    step(1);
    start = 1'b0;
    mode  = 2'd0;
  endtask

  int done_cnt;

  initial begin
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_phase", phase, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    step(1);

    // Mode 1 full programme: phases 1..5 for 4,6,6,4,4 cycles, done in cycle 25.
    go(2'd1);
    for (int c = 1; c <= 25; c++) begin
      chk("m1_phase", phase, (c <= 4) ? 1 : (c <= 10) ? 2 : (c <= 16) ? 3 : (c <= 20) ? 4 : (c <= 24) ? 5 : 0);
      chk("m1_busy", busy, (c <= 24) ? 1 : 0);
      chk("m1_done", done, (c == 25) ? 1 : 0);
      if (c == 1) chk("m1_rem_c1", remaining, 2);
      if (c == 4) chk("m1_rem_c4", remaining, 1);
      if (c == 1) chk("m1_valve_c1", water_valve, 1);
      step(1);
    end

    // Mode 3 spin-only, then a mode 2 start coinciding with the done pulse.
    step(2);
    go(2'd3);
    for (int c = 1; c <= 4; c++) begin
      chk("m3_phase", phase, 5);
      chk("m3_spin_en", spin_en, 1);
      chk("m3_valve", water_valve, 0);
      step(1);
    end
    chk("m3_done", done, 1);
    go(2'd2);
    chk("m2_on_done_phase", phase, 1);
    step(20);

    // Lid open for 5 cycles in WASH delays done to cycle 30.
    go(2'd1);
    step(11);
    lid = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("lid_paused", paused, 1);
      chk("lid_wash_en", wash_en, 0);
      chk("lid_phase", phase, 3);
      chk("lid_remaining", remaining, 3);
      step(1);
    end
    lid = 1'b0;
    step(12);
    chk("lid_done_c29", done, 0);
    step(1);
    chk("lid_done_c30", done, 1);
    step(2);

    // Cancel on the final SOAK tick wins; done never follows.
    go(2'd1);
    step(9);
    chk("cxl_pre_phase", phase, 2);
    chk("cxl_pre_rem", remaining, 1);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    chk("cxl_phase", phase, 0);
    chk("cxl_aborted", aborted, 1);
    chk("cxl_remaining", remaining, 0);
    step(1);
    chk("cxl_aborted_once", aborted, 0);
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      done_cnt += int'(done);
      step(1);
    end
    chk("cxl_no_done", done_cnt, 0);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    chk("cxl_idle_ignored", aborted, 0);

    // Ignored starts: mode 0, lid open, cancel together, and while busy.
    go(2'd0);
    chk("ign_mode0", busy, 0);
    lid = 1'b1;
    go(2'd1);
    lid = 1'b0;
    chk("ign_lid", busy, 0);
    cancel = 1'b1;
    go(2'd1);
    cancel = 1'b0;
    chk("ign_cancel", busy, 0);
    go(2'd1);
    go(2'd3);
    chk("ign_busy_phase", phase, 1);
    chk("ign_busy_rem", remaining, 2);
    step(23);
    chk("ign_busy_done", done, 1);
    step(2);

    // Reset mid-RINSE clears outputs at once.
    go(2'd1);
    step(17);
    chk("rst_mid_pre", phase, 4);
    chk("rst_mid_rinse", rinse_en, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_phase", phase, 0);
    chk("rst_mid_rinse_en", rinse_en, 0);
    chk("rst_mid_rem", remaining, 0);
    chk("rst_mid_done", done, 0);
    step(2);
    reset = 1'b0;
    step(2);
    chk("rst_after_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wash_phase_sequencer.md
# wash_phase_sequencer

Times and sequences the physical wash phases (fill, soak, wash, rinse, spin) for one selected programme, driving the valve and motor-phase enables. It sits below the top-level washer controller. The controller issues `start` with a mode once a paid cycle is ready. The sequencer owns all phase durations, lid-pause handling and cancel abort, and reports `done` or `aborted` back to the controller.

## Interface
Parameters:
- `TICK_DIV`, 1000: clock cycles per phase tick (≥1).
- `CNT_W`, 8: width of the phase tick counter.
- `FILL_TICKS`, 10: fill phase length in ticks.
- `SOAK_TICKS`, 30: soak phase length in ticks.
- `WASH_TICKS`, 40: wash phase length in ticks.
- `RINSE_TICKS`, 20: rinse phase length in ticks.
- `SPIN_TICKS`, 15: spin phase length in ticks.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a programme.
- `mode`  in  2  programme select, sampled on accepted `start`: 1 full, 2 quick (no soak), 3 spin-only, 0 illegal.
- `lid`  in  1  1 = lid open.
- `cancel`  in  1  abort request.
- `busy`  out  1  high in every non-IDLE state.
- `phase`  out  3  current state code.
- `water_valve`  out  1  high in FILL while not paused.
- `soak_en`, `wash_en`, `rinse_en`, `spin_en`  out  1 each  high in their phase while not paused.
- `paused`  out  1  lid-pause active.
- `remaining`  out  CNT_W  ticks left in the current phase.
- `done`  out  1  one-cycle pulse on normal completion.
- `aborted`  out  1  one-cycle pulse on cancel.

## Operation
- States and codes: IDLE 0, FILL 1, SOAK 2, WASH 3, RINSE 4, SPIN 5, RINSE2 6 (RINSE2 exists only with the macro).
- Sequences:
  - mode 1: FILL→SOAK→WASH→RINSE→SPIN→IDLE.
  - mode 2: FILL→WASH→RINSE→SPIN→IDLE.
  - mode 3: SPIN→IDLE.
- `start` is accepted only in IDLE, with `lid`=0, `cancel`=0 and `mode`≠0. Otherwise it is ignored with no state change.
- `mode` is latched on acceptance. Later `mode` changes have no effect until the next accepted `start`.
- Phase entry:
  - `remaining` loads the phase tick count.
  - Prescaler clears to 0.
- Counting:
  - Prescaler counts 0..TICK_DIV-1 and emits a tick when it wraps.
  - Each tick decrements `remaining`.
  - The tick that takes `remaining` from 1 to 0 ends the phase, and the next state is entered on the following edge.
  - A phase parameter of 0 gives a one-cycle phase.
- Lid pause:
  - `lid`=1 in any non-IDLE state sets `paused`=1.
  - Prescaler and `remaining` freeze.
  - All enables and `water_valve` drop combinationally with `paused`.
  - `lid`=0 resumes counting from the frozen values.
- Cancel:
  - `cancel`=1 in any non-IDLE state forces IDLE on the next edge.
  - `aborted` pulses in that first IDLE cycle, and `remaining` clears.
  - Cancel outranks lid and tick.
  - Cancel in IDLE is ignored.
- Completion: when SPIN ends, the next cycle is IDLE with `done`=1 for exactly one cycle.
- Reset, including mid-phase: state IDLE, all outputs 0, `phase`=0, `remaining`=0, prescaler 0, latched mode 0.

## Timing
- Accepted `start` at edge N: first phase state, its enable and `busy` are visible after edge N+1.
- Unpaused phase length is exactly ticks×TICK_DIV cycles, or 1 cycle if ticks=0.
- Pause cycles add one-for-one to phase length.
- Cancel and tick on the same cycle: cancel wins, and `done` never pulses.
- `start` coinciding with `done` or `aborted` cycle (state IDLE): accepted normally.
- `remaining` and `phase` are registered. Enables are decoded from the state and `paused`.

## Configuration
- `EXTRA_RINSE_EN` defined:
  - RINSE2 (code 6, `rinse_en`=1, RINSE_TICKS long) is inserted between RINSE and SPIN for mode 1 only.
  - Modes 2 and 3 are unchanged.
- Undefined: RINSE2 state does not exist, and code 6 is never output.

## Test plan
All scenarios use TICK_DIV=2, FILL=2, SOAK=3, WASH=3, RINSE=2, SPIN=2, macro off.

- Mode 1 `start` at cycle 0 -> `phase` 1,2,3,4,5 for 4,6,6,4,4 cycles; `busy` high cycles 1–24; `done` pulse cycle 25.
- Mode 3 `start` -> `phase`=5, `spin_en` 4 cycles, `done`; `water_valve` never high.
- Mode 1, `lid`=1 for 5 cycles mid-WASH -> `paused`=1, `wash_en`=0, `remaining` frozen; `done` delayed to cycle 30.
- `cancel` in SOAK coinciding with a final tick -> IDLE next cycle; `aborted`=1 once; `done` never asserted.
- `start` with `mode`=0, with `lid`=1, or while `busy` -> no state change.
- Assert `reset` mid-RINSE -> all outputs 0 immediately. With the macro on, the mode 1 sequence includes `phase`=6 for 4 cycles and `done` moves to cycle 29.
